axi_read_arbiter_2to1: RTL and testbench

Two-master to one-slave read-channel arbiter for the simplified AXI (SAXI) environment. It shares one read slave between two independent read masters. AR transfers are granted round-robin, and the master index is prefixed onto the slave-side ID. Out-of-order R responses are routed back by that ID prefix, and outstanding reads are limited per master.

---
 rtl/axi_read_arbiter_2to1.sv | 108 ++++++++++
 tb/tb_axi_read_arbiter_2to1.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter_2to1.sv
// Two-master to one-slave AXI read arbiter: round-robin AR grant with the master
// index prefixed onto the slave ID, combinational R return by that prefix.
module axi_read_arbiter_2to1 #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MAX_OUTST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [ID_W-1:0]   m0_rid,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ID_W-1:0]   m1_rid,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [ID_W:0]     s_arid,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [ID_W:0]     s_rid,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic              stray_err
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

    logic          state, gnt, last;
    logic [CW-1:0] cnt0, cnt1;
    logic          elig0, elig1, winner;
    logic          ar_hs, r_hs, rt;

    assign elig0  = m0_arvalid && (cnt0 < CW'(MAX_OUTST));
    assign elig1  = m1_arvalid && (cnt1 < CW'(MAX_OUTST));
    assign winner = (elig0 && elig1) ? ~last : elig1;

    assign s_arvalid  = (state == GRANT) && (gnt ? m1_arvalid : m0_arvalid);
    assign s_araddr   = gnt ? m1_araddr : m0_araddr;
    assign s_arid     = {gnt, (gnt ? m1_arid : m0_arid)};
    assign m0_arready = (state == GRANT) && !gnt && s_arready;
    assign m1_arready = (state == GRANT) &&  gnt && s_arready;
    assign ar_hs      = s_arvalid && s_arready;

    // R path is pure wiring; rst gating keeps valids/readies low while in reset.
    assign rt        = s_rid[ID_W];
    assign m0_rvalid = rst && s_rvalid && !rt;
    assign m1_rvalid = rst && s_rvalid &&  rt;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rid    = s_rid[ID_W-1:0];
    assign m1_rid    = s_rid[ID_W-1:0];
    assign s_rready  = rst && (rt ? m1_rready : m0_rready);
    assign r_hs      = s_rvalid && s_rready;

    // Saturating up/down; simultaneous issue and return cancel out.
    function automatic logic [CW-1:0] cnt_upd(input logic [CW-1:0] c, input logic inc,
                                              input logic dec);
        if (inc && !dec && c < CW'(MAX_OUTST)) return c + 1'b1;
        if (dec && !inc && c != '0)           return c - 1'b1;
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (elig0 || elig1) begin
                    gnt   <= winner;
                    state <= GRANT;
                end
                GRANT: if (ar_hs) begin
                    last  <= gnt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0      <= '0;
            cnt1      <= '0;
            stray_err <= 1'b0;
        end else begin
            cnt0 <= cnt_upd(cnt0, ar_hs && !gnt, r_hs && !rt);
            cnt1 <= cnt_upd(cnt1, ar_hs &&  gnt, r_hs &&  rt);
            if (r_hs && (rt ? (cnt1 == '0) : (cnt0 == '0)))
                stray_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_read_arbiter_2to1.sv
// Random traffic against a queue-based reference model, then directed reset,
// routing, stray and contention cases.
module tb_axi_read_arbiter_2to1;
    localparam int ADDR_W = 32, DATA_W = 32, ID_W = 4, MAX_OUTST = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        mv, rr;
    logic [ADDR_W-1:0] ma [2];
    logic [ID_W-1:0]   mid[2];
    logic              m0_arready, m1_arready, m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [ID_W-1:0]   m0_rid, m1_rid;
    logic [ADDR_W-1:0] s_araddr;
    logic [ID_W:0]     s_arid, s_rid;
    logic              s_arvalid, s_arready, s_rvalid, s_rready, stray_err;
    logic [DATA_W-1:0] s_rdata;

    axi_read_arbiter_2to1 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
                            .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(ma[0]), .m0_arid(mid[0]), .m0_arvalid(mv[0]), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rid(m0_rid), .m0_rvalid(m0_rvalid), .m0_rready(rr[0]),
        .m1_araddr(ma[1]), .m1_arid(mid[1]), .m1_arvalid(mv[1]), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rid(m1_rid), .m1_rvalid(m1_rvalid), .m1_rready(rr[1]),
        .s_araddr(s_araddr), .s_arid(s_arid), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rid(s_rid), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .stray_err(stray_err)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // reference model: pending grant plus one queue of outstanding IDs per master
    bit              pend, g, last_m, stray_m, hs_ar, hs_r, hs_t, e0, e1, drop, drop_i, pick;
    bit              exp_rr;
    int              idx;
    logic [ID_W-1:0] q0[$], q1[$];
    logic [ID_W-1:0] rid_l;

    initial begin
        mv = '0; rr = 2'b11; ma = '{default: '0}; mid = '{default: '0};
        s_arready = 1'b0; s_rvalid = 1'b1; s_rid = '0; s_rdata = '0;
        #2;
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_m0_arready", m0_arready, 0);
        chk("rst_stray", stray_err, 0);
        @(negedge clk);
        s_rvalid = 1'b0;
        rst = 1'b1;

        pend = 0; last_m = 1; stray_m = 0; drop = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (drop) mv[drop_i] = 1'b0;
            for (int i = 0; i < 2; i++)
                if (!mv[i] && $urandom_range(0, 2) != 0) begin
                    mv[i]  = 1'b1;
                    ma[i]  = $urandom;
                    mid[i] = ID_W'($urandom_range(0, 15));
                end
            s_arready = ($urandom_range(0, 3) != 0);
            rr[0] = ($urandom_range(0, 3) != 0);
            rr[1] = ($urandom_range(0, 3) != 0);
            s_rvalid = 1'b0;
            if ($urandom_range(0, 2) == 0 && (q0.size() + q1.size()) > 0) begin
                pick = (q0.size() == 0) ? 1'b1 : (q1.size() == 0) ? 1'b0
                                                 : 1'($urandom_range(0, 1));
                if (pick) begin idx = $urandom_range(0, q1.size() - 1); rid_l = q1[idx]; end
                else      begin idx = $urandom_range(0, q0.size() - 1); rid_l = q0[idx]; end
                s_rid = {pick, rid_l};
                s_rdata = $urandom;
                s_rvalid = 1'b1;
            end
            #1;
            hs_t   = s_rid[ID_W];
            exp_rr = rr[hs_t];
            chk("s_arvalid", s_arvalid, pend && mv[g]);
            if (pend && mv[g]) begin
                chk("s_arid", s_arid, {g, mid[g]});
                chk("s_araddr", s_araddr, ma[g]);
            end
            chk("m0_arready", m0_arready, pend && !g && s_arready);
            chk("m1_arready", m1_arready, pend &&  g && s_arready);
            chk("m0_rvalid", m0_rvalid, s_rvalid && !hs_t);
            chk("m1_rvalid", m1_rvalid, s_rvalid &&  hs_t);
            chk("s_rready", s_rready, exp_rr);
            if (s_rvalid) begin
                chk("r_rid", hs_t ? m1_rid : m0_rid, s_rid[ID_W-1:0]);
                chk("r_rdata", hs_t ? m1_rdata : m0_rdata, s_rdata);
            end
            chk("stray_err", stray_err, stray_m);
            hs_ar = pend && mv[g] && s_arready;
            hs_r  = s_rvalid && exp_rr;
            e0 = mv[0] && q0.size() < MAX_OUTST;
            e1 = mv[1] && q1.size() < MAX_OUTST;
            @(posedge clk);
            if (hs_r) begin
                if (hs_t) begin
                    if (q1.size() == 0) stray_m = 1;
                    foreach (q1[k]) if (q1[k] == s_rid[ID_W-1:0]) begin q1.delete(k); break; end
                end else begin
                    if (q0.size() == 0) stray_m = 1;
                    foreach (q0[k]) if (q0[k] == s_rid[ID_W-1:0]) begin q0.delete(k); break; end
                end
            end
            drop = hs_ar;
            drop_i = g;
            if (hs_ar) begin
                if (g) q1.push_back(mid[1]); else q0.push_back(mid[0]);
                last_m = g;
                pend = 0;
            end else if (!pend && (e0 || e1)) begin
                pend = 1;
                g = (e0 && e1) ? !last_m : e1;
            end
        end

        // directed: single-master read and response
        @(negedge clk);
        mv = '0; s_rvalid = 1'b0; s_arready = 1'b0; rr = 2'b11;
        rst = 1'b0;
        #1;
        chk("rst2_s_arvalid", s_arvalid, 0);
        chk("rst2_stray", stray_err, 0);
        @(negedge clk);
        rst = 1'b1;
        mv[0] = 1'b1; ma[0] = 'h100; mid[0] = 4'd3; s_arready = 1'b1;
        #1 chk("sm_idle_arvalid", s_arvalid, 0);
        @(negedge clk); #1;
        chk("sm_arvalid", s_arvalid, 1);
        chk("sm_arid", s_arid, 'h03);
        chk("sm_araddr", s_araddr, 'h100);
        chk("sm_arready", m0_arready, 1);
        @(negedge clk);
        mv[0] = 1'b0; s_rvalid = 1'b1; s_rid = 'h03; s_rdata = 'h123;
        #1;
        chk("sm_rvalid", m0_rvalid, 1);
        chk("sm_rid", m0_rid, 3);
        chk("sm_rdata", m0_rdata, 'h123);
        chk("sm_m1_rvalid", m1_rvalid, 0);
        chk("sm_bubble", s_arvalid, 0);
        // stray to m0 (counter back at zero)
        @(negedge clk);
        s_rid = 'h05; s_rdata = 'h55;
        #1;
        chk("st_no_stray_yet", stray_err, 0);
        chk("st_m0_rid", m0_rid, 5);
        chk("st_m0_rvalid", m0_rvalid, 1);
        // backpressure on m1
        @(negedge clk);
        s_rid = 'h10; rr[1] = 1'b0;
        #1;
        chk("st_stray_set", stray_err, 1);
        chk("bp_s_rready", s_rready, 0);
        chk("bp_m1_rvalid", m1_rvalid, 1);
        chk("bp_m0_rvalid", m0_rvalid, 0);
        // async reset while granted
        @(negedge clk);
        s_rvalid = 1'b0; rr[1] = 1'b1;
        mv[1] = 1'b1; ma[1] = 'h200; mid[1] = 4'd7; s_arready = 1'b0;
        @(negedge clk); #1;
        chk("ar_grant_vld", s_arvalid, 1);
        chk("ar_grant_id", s_arid, 'h17);
        chk("st_sticky", stray_err, 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_rst_vld", s_arvalid, 0);
        chk("ar_rst_rdy", m1_arready, 0);
        chk("ar_rst_stray", stray_err, 0);
        @(negedge clk);
        rst = 1'b1; mv[1] = 1'b0;
        s_rvalid = 1'b1; s_rid = 'h12; s_rdata = 'h77;
        #1 chk("post_rst_m1_rvalid", m1_rvalid, 1);
        @(negedge clk); #1;
        chk("post_rst_stray", stray_err, 1);
        // contention: alternating grants with a bubble between
        s_rvalid = 1'b0; mv = 2'b11; s_arready = 1'b1;
        ma[0] = 'h300; ma[1] = 'h400; mid[0] = 4'd1; mid[1] = 4'd2;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("cont_vld", s_arvalid, k % 2);
            if (k % 2) chk("cont_who", s_arid[ID_W], (k / 2) % 2);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
